moore_sm: RTL and testbench



---
 rtl/moore_sm_pkg.sv | 29 ++
 rtl/moore_sm.sv | 35 +++
 tb/tb_moore_sm.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/moore_sm_pkg.sv
// Shared types for the 1-0-1-1 Moore pattern detector: state encoding and
// the state-to-output decode used by the top.
package moore_sm_pkg;

  localparam int OUT_W = 3;

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_t;

  // Output code is state index + 1; any unused encoding reads as idle (1).
  function automatic logic [OUT_W-1:0] state_to_out(input state_t s);
    logic [OUT_W-1:0] o;
    case (s)
      S0:      o = 3'd1;
      S1:      o = 3'd2;
      S2:      o = 3'd3;
      S3:      o = 3'd4;
      S4:      o = 3'd5;
      default: o = 3'd1;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/moore_sm.sv
// Moore detector for the serial pattern 1-0-1-1 (overlap allowed).
// out reports the registered state as index+1; out==5 means detected.
module moore_sm
  import moore_sm_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  output logic [OUT_W-1:0] out
);

  state_t state;
  state_t state_next;

  always_ff @(posedge clk) begin
    if (!reset) state <= S0;
    else        state <= state_next;
  end

  // Each state records the longest pattern prefix that is a suffix of the input.
  always_comb begin
    state_next = S0;
    case (state)
      S0:      state_next = in ? S1 : S0;
      S1:      state_next = in ? S1 : S2;
      S2:      state_next = in ? S3 : S0;
      S3:      state_next = in ? S4 : S2;
      S4:      state_next = in ? S1 : S2;
      default: state_next = S0;
    endcase
  end

  assign out = state_to_out(state);

endmodule

// File: tb/tb_moore_sm.sv
// Bench for moore_sm: directed steps from the test plan plus randomized
// traffic, checked against a suffix-matching model of the pattern detector.
module tb_moore_sm;

  logic       clk;
  logic       reset;
  logic       in;
  logic [2:0] out;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the bits seen since the last reset (last four kept).
  logic       hist[$];
  logic [2:0] exp_q[$];
  bit         known = 0;

  moore_sm dut (
    .clk   (clk),
    .reset (reset),
    .in    (in),
    .out   (out)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Longest suffix of the history that is a prefix of 1-0-1-1 gives the
  // progress k; the expected code is k+1.
  function automatic logic [2:0] model_out();
    logic pat[4];
    int   n;
    bit   ok;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b1;
    n = hist.size();
    for (int k = 4; k >= 1; k--) begin
      if (n >= k) begin
        ok = 1'b1;
        for (int i = 0; i < k; i++)
          if (hist[n-k+i] !== pat[i]) ok = 1'b0;
        if (ok) return 3'(k + 1);
      end
    end
    return 3'd1;
  endfunction

  task automatic check(input string tag, input logic [2:0] exp);
    n_tests++;
    assert (out === exp)
      else begin
        n_fail++;
        $error("FAIL %s: out=%0d expected %0d at %0t", tag, out, exp, $time);
      end
  endtask

  // One rising edge: update the model from the sampled inputs, then check.
  task automatic tick();
    logic       r;
    logic       b;
    logic [2:0] e;
    @(posedge clk);
    r = reset;
    b = in;
    if (!r) begin
      hist.delete();
      known = 1'b1;
    end else if (known) begin
      hist.push_back(b);
      if (hist.size() > 4) void'(hist.pop_front());
    end
    #1;
    if (known) begin
      exp_q.push_back(model_out());
      e = exp_q.pop_front();
      check("model", e);
      n_tests++;
      assert ((out >= 3'd1) && (out <= 3'd5))
        else begin
          n_fail++;
          $error("FAIL range: out=%0d expected 1..5 at %0t", out, $time);
        end
      if (!r) check("reset_low", 3'd1);
    end
  endtask

  // Drive one cycle and also compare against a hand-derived constant.
  task automatic step(input logic r, input logic b, input logic [2:0] exp,
                      input string tag);
    reset = r;
    in    = b;
    tick();
    check(tag, exp);
  endtask

  task automatic drive(input logic r, input logic b);
    reset = r;
    in    = b;
    tick();
  endtask

  initial begin
    reset = 1'b0;
    in    = 1'b1;

    // Reset held two edges with in=1, then release.
    step(0, 1, 3'd1, "rst_hold0");
    step(0, 1, 3'd1, "rst_hold1");
    step(1, 1, 3'd2, "rst_release");

    // Detection from S0.
    step(0, 0, 3'd1, "to_s0_a");
    step(1, 1, 3'd2, "det_1");
    step(1, 0, 3'd3, "det_10");
    step(1, 1, 3'd4, "det_101");
    step(1, 1, 3'd5, "det_1011");

    // Overlap: second detection reuses the trailing 1.
    step(0, 0, 3'd1, "to_s0_b");
    step(1, 1, 3'd2, "ovl_0");
    step(1, 0, 3'd3, "ovl_1");
    step(1, 1, 3'd4, "ovl_2");
    step(1, 1, 3'd5, "ovl_3");
    step(1, 0, 3'd3, "ovl_4");
    step(1, 1, 3'd4, "ovl_5");
    step(1, 1, 3'd5, "ovl_6");

    // Mid-sequence reset, then release with in=0.
    step(0, 0, 3'd1, "to_s0_c");
    step(1, 1, 3'd2, "mid_1");
    step(1, 0, 3'd3, "mid_10");
    step(1, 1, 3'd4, "mid_101");
    step(0, 1, 3'd1, "mid_rst");
    step(1, 0, 3'd1, "mid_rel0");

    // Dead-ends and holds.
    step(1, 1, 3'd2, "hold1_a");
    step(1, 1, 3'd2, "hold1_b");
    step(1, 1, 3'd2, "hold1_c");
    step(1, 0, 3'd3, "s1_0");
    step(1, 0, 3'd1, "s2_0");
    step(1, 1, 3'd2, "s0_1");
    step(1, 0, 3'd3, "s1_0b");
    step(1, 1, 3'd4, "s2_1");
    step(1, 0, 3'd3, "s3_0");
    step(1, 1, 3'd4, "s2_1b");
    step(1, 1, 3'd5, "s3_1");
    step(1, 0, 3'd3, "s4_0");

    // Slow stimulus: inputs change off the clock grid, reset low for 50 ns.
    fork
      begin
        reset = 1'b1;
        in    = 1'b1;
        #14 in    = 1'b0;
        #50 in    = 1'b1;
        #40 reset = 1'b0;
        #50 reset = 1'b1;
        #30;
      end
      begin
        repeat (9) tick();
      end
    join

    // Randomized traffic with occasional resets.
    repeat (400) begin
      drive(($urandom_range(0, 19) != 0), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
